grid_cell_scanner: RTL

Inverse of the pixel-to-grid mapping. The block accepts a grid cell coordinate and emits, one per accepted beat, every VGA pixel coordinate covered by that cell, in raster order. It sits between game/draw logic, which issues cell paint requests, and the frame-buffer write port, which consumes pixel coordinates. Valid/ready handshakes are used on both sides.

---
 rtl/grid_cell_scanner_if.sv | 27 ++
 rtl/grid_cell_scanner.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/grid_cell_scanner_if.sv
// Request/pixel handshake bundle between the cell painter, the scanner and
// the frame-buffer write port.
interface grid_cell_scanner_if;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  cell_x;
   logic [5:0]  cell_y;
   logic [10:0] pos_h;
   logic [9:0]  pos_v;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
   logic        busy;
   logic        done;

   // requester / pixel consumer side
   modport master (
      output req_valid, cell_x, cell_y, pix_ready,
      input  req_ready, pos_h, pos_v, pix_valid, pix_last, busy, done
   );

   // scanner side
   modport slave (
      input  req_valid, cell_x, cell_y, pix_ready,
      output req_ready, pos_h, pos_v, pix_valid, pix_last, busy, done
   );
endinterface

// File: rtl/grid_cell_scanner.sv
// Expands one grid cell request into its pixel coordinates in raster order.
//
// state  | meaning
// S_IDLE | waiting for a cell request, req_ready high
// S_SCAN | emitting the pixels of the captured cell, one per accepted beat
module grid_cell_scanner #(
   parameter int GRID_WIDTH        = 80,
   parameter int GRID_HEIGHT       = 40,
   parameter int PIXELS_PER_GRID_X = 8,
   parameter int PIXELS_PER_GRID_Y = 12
) (
   input logic                 clk,
   input logic                 rst,
   grid_cell_scanner_if.slave  bus
);

   localparam int DXW = (PIXELS_PER_GRID_X > 1) ? $clog2(PIXELS_PER_GRID_X) : 1;
   localparam int DYW = (PIXELS_PER_GRID_Y > 1) ? $clog2(PIXELS_PER_GRID_Y) : 1;
   localparam logic [DXW-1:0] DX_MAX = DXW'(PIXELS_PER_GRID_X - 1);
   localparam logic [DYW-1:0] DY_MAX = DYW'(PIXELS_PER_GRID_Y - 1);
   localparam logic [6:0]     CX_MAX = 7'(GRID_WIDTH - 1);
   localparam logic [5:0]     CY_MAX = 6'(GRID_HEIGHT - 1);

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t           state_q, state_d;
   logic [DXW-1:0]   dx_q, dx_d;
   logic [DYW-1:0]   dy_q, dy_d;
   logic [10:0]      ox_q, ox_d;
   logic [10:0]      pos_h_q, pos_h_d;
   logic [9:0]       pos_v_q, pos_v_d;
   logic             pix_valid_q, pix_valid_d;
   logic             pix_last_q, pix_last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             req_ready_q, req_ready_d;

   logic [6:0]       cx;
   logic [5:0]       cy;
   logic [10:0]      ox;
   logic [9:0]       oy;
   logic             last_beat;

   // Clamp the requested cell onto the grid and derive its pixel origin.
   always_comb begin
      cx = (bus.cell_x > CX_MAX) ? CX_MAX : bus.cell_x;
      cy = (bus.cell_y > CY_MAX) ? CY_MAX : bus.cell_y;
      ox = 11'(cx) * 11'(PIXELS_PER_GRID_X);
      oy = 10'(cy) * 10'(PIXELS_PER_GRID_Y);
   end

   assign last_beat = (dx_q == DX_MAX) && (dy_q == DY_MAX);

   // Next-state and next-output computation for the scan FSM.
   always_comb begin
      state_d     = state_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      ox_d        = ox_q;
      pos_h_d     = pos_h_q;
      pos_v_d     = pos_v_q;
      pix_valid_d = pix_valid_q;
      busy_d      = busy_q;
      req_ready_d = req_ready_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               state_d     = S_SCAN;
               ox_d        = ox;
               pos_h_d     = ox;
               pos_v_d     = oy;
               dx_d        = '0;
               dy_d        = '0;
               pix_valid_d = 1'b1;
               busy_d      = 1'b1;
               req_ready_d = 1'b0;
            end
         end
         S_SCAN: begin
            if (bus.pix_ready) begin
               if (last_beat) begin
                  state_d     = S_IDLE;
                  pix_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  req_ready_d = 1'b1;
                  done_d      = 1'b1;
               end else if (dx_q != DX_MAX) begin
                  dx_d    = dx_q + 1'b1;
                  pos_h_d = pos_h_q + 11'd1;
               end else begin
                  dx_d    = '0;
                  dy_d    = dy_q + 1'b1;
                  pos_h_d = ox_q;
                  pos_v_d = pos_v_q + 10'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flag is derived from the offsets it will be paired with, so it holds
      // along with pos_h/pos_v under backpressure.
      pix_last_d = (state_d == S_SCAN) && (dx_d == DX_MAX) && (dy_d == DY_MAX);
   end

   // State and registered outputs; reset aborts any scan without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         dx_q        <= '0;
         dy_q        <= '0;
         ox_q        <= '0;
         pos_h_q     <= '0;
         pos_v_q     <= '0;
         pix_valid_q <= 1'b0;
         pix_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         req_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         ox_q        <= ox_d;
         pos_h_q     <= pos_h_d;
         pos_v_q     <= pos_v_d;
         pix_valid_q <= pix_valid_d;
         pix_last_q  <= pix_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.pos_h     = pos_h_q;
   assign bus.pos_v     = pos_v_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_last  = pix_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
